// File: rtl/ymat_row_addr_gen.sv
// Y-matrix row-address generator: walks a run of row indices and emits one SRAM
// address beat per index (or per SRAM word touched when YMAT_WORD_MERGE_EN is defined).
module ymat_row_addr_gen #(
  parameter int unsigned IDX_W  = 11,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned BASE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  start_row,
  input  logic [IDX_W-1:0]  count,
  output logic              busy,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [SHIFT-1:0]  lane,
  output logic [SHIFT:0]    lane_cnt,
  output logic              last,
  output logic              done
);

  localparam int unsigned CW = (IDX_W > SHIFT + 1) ? IDX_W : SHIFT + 1;
  localparam logic [ADDR_W-1:0] BASE_W = ADDR_W'(BASE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  logic             run;
  logic [IDX_W-1:0] word_idx;
  logic [SHIFT:0]   cnt_w;
  logic             last_w;

  assign run      = (state_q == RUN);
  assign word_idx = cur_q >> SHIFT;

`ifdef YMAT_WORD_MERGE_EN
  logic [SHIFT:0] room;
  logic [CW-1:0]  rem_x;
  logic [CW-1:0]  room_x;

  // Entries left in the current SRAM word starting from the current lane.
  assign room   = {1'b1, {SHIFT{1'b0}}} - {1'b0, cur_q[SHIFT-1:0]};
  assign rem_x  = CW'(rem_q);
  assign room_x = CW'(room);
  assign cnt_w  = (rem_x < room_x) ? (SHIFT+1)'(rem_x) : room;
`else
  assign cnt_w  = (SHIFT+1)'(1);
`endif

  assign last_w = (CW'(rem_q) == CW'(cnt_w));

  // Beat fields come only from registered state, gated to zero outside RUN.
  assign busy       = run;
  assign addr_valid = run;
  assign addr       = run ? (BASE_W + ADDR_W'(word_idx)) : '0;
  assign lane       = run ? cur_q[SHIFT-1:0] : '0;
  assign lane_cnt   = run ? cnt_w : '0;
  assign last       = run & last_w;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d = RUN;
            cur_d   = start_row;
            rem_d   = count;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (addr_ready) begin
          cur_d = cur_q + IDX_W'(cnt_w);
          rem_d = rem_q - IDX_W'(cnt_w);
          if (last_w) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ymat_row_addr_gen.sv
// Self-checking bench for ymat_row_addr_gen; two instances (BASE=0 and BASE=2040)
// share stimulus and are checked against a beat-list model of the run.
`timescale 1ns/1ps
module tb_ymat_row_addr_gen;

  localparam int unsigned IW     = 11;
  localparam int unsigned SH     = 4;
  localparam int unsigned AW     = 11;
  localparam int unsigned BASE_B = 2040;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          addr_ready;
  logic [IW-1:0] start_row;
  logic [IW-1:0] count;

  logic          busy, addr_valid, last, done;
  logic [AW-1:0] addr;
  logic [SH-1:0] lane;
  logic [SH:0]   lane_cnt;
  logic          busy_b, valid_b, last_b, done_b;
  logic [AW-1:0] addr_b;
  logic [SH-1:0] lane_b;
  logic [SH:0]   cnt_b;

  ymat_row_addr_gen #(.IDX_W(IW), .SHIFT(SH), .ADDR_W(AW), .BASE(0)) dut (
    .clock(clock), .reset(reset), .start(start), .start_row(start_row), .count(count),
    .busy(busy), .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .lane(lane), .lane_cnt(lane_cnt), .last(last), .done(done)
  );

  ymat_row_addr_gen #(.IDX_W(IW), .SHIFT(SH), .ADDR_W(AW), .BASE(BASE_B)) dut_b (
    .clock(clock), .reset(reset), .start(start), .start_row(start_row), .count(count),
    .busy(busy_b), .addr_valid(valid_b), .addr_ready(addr_ready), .addr(addr_b),
    .lane(lane_b), .lane_cnt(cnt_b), .last(last_b), .done(done_b)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned addr;
    int unsigned addr_b;
    int unsigned lane;
    int unsigned cnt;
    bit          last;
  } beat_t;

  beat_t exp_q[$];

  logic [47:0] obs;
  assign obs = {busy, addr_valid, addr, lane, lane_cnt, last, done,
                busy_b, valid_b, addr_b, lane_b, cnt_b, last_b, done_b};

  localparam logic [47:0] DONE_VEC = {24'd1, 24'd1};
  localparam logic [47:0] ZERO_VEC = '0;

  // Reference: list every beat the run should produce, in order.
  function automatic void model_run(int unsigned sr, int unsigned cnt);
    int unsigned idx, left, n, words;
    beat_t b;
    words = 1 << SH;
    exp_q.delete();
    idx  = sr;
    left = cnt;
    while (left > 0) begin
`ifdef YMAT_WORD_MERGE_EN
      n = words - (idx % words);
      if (n > left) n = left;
`else
      n = 1;
`endif
      b.addr   = (idx / words) % (1 << AW);
      b.addr_b = (BASE_B + idx / words) % (1 << AW);
      b.lane   = idx % words;
      b.cnt    = n;
      b.last   = (n == left);
      exp_q.push_back(b);
      idx  = (idx + n) % (1 << IW);
      left = left - n;
    end
  endfunction

  function automatic logic [23:0] one(int unsigned a, int unsigned ln, int unsigned c, bit lst);
    return {2'b11, AW'(a), SH'(ln), (SH+1)'(c), lst, 1'b0};
  endfunction

  function automatic logic [47:0] beat_vec(beat_t b);
    return {one(b.addr, b.lane, b.cnt, b.last), one(b.addr_b, b.lane, b.cnt, b.last)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; addr_ready = 1'b0; start_row = '0; count = '0;
    repeat (3) tick();
    total++;
    if (obs !== ZERO_VEC) begin bad++; $display("FAIL reset_state got=%h want=%h", obs, ZERO_VEC); end
    reset = 1'b0;
    tick();
    total++;
    if (obs !== ZERO_VEC) begin bad++; $display("FAIL idle_after_reset got=%h want=%h", obs, ZERO_VEC); end
  endtask

  task automatic test_basic();
    int unsigned srs[6]  = '{37, 2046, 14, 0, 2047, 2040};
    int unsigned cnts[6] = '{3, 3, 20, 1, 1, 16};
    int unsigned cyc;
    addr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      model_run(srs[k], cnts[k]);
      start = 1'b1; start_row = IW'(srs[k]); count = IW'(cnts[k]);
      tick();
      start = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
        total++;
        if (obs !== beat_vec(exp_q[0])) begin
          bad++; $display("FAIL basic_beat case=%0d cyc=%0d got=%h want=%h", k, cyc, obs, beat_vec(exp_q[0]));
        end
        tick();
        void'(exp_q.pop_front());
        cyc++;
      end
      total++;
      if (obs !== DONE_VEC) begin bad++; $display("FAIL basic_done case=%0d got=%h want=%h", k, obs, DONE_VEC); end
    end
    tick();
    total++;
    if (obs !== ZERO_VEC) begin bad++; $display("FAIL basic_done_pulse got=%h want=%h", obs, ZERO_VEC); end
  endtask

  task automatic test_backpressure();
    int unsigned cyc;
    model_run(37, 3);
    start = 1'b1; start_row = IW'(37); count = IW'(3); addr_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      total++;
      if (obs !== beat_vec(exp_q[0])) begin
        bad++; $display("FAIL bp_beat cyc=%0d got=%h want=%h", cyc, obs, beat_vec(exp_q[0]));
      end
      addr_ready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
      tick();
      if (addr_ready) void'(exp_q.pop_front());
      cyc++;
    end
    total++;
    if (obs !== DONE_VEC) begin bad++; $display("FAIL bp_done got=%h want=%h", obs, DONE_VEC); end
    tick();
    total++;
    if (obs !== ZERO_VEC) begin bad++; $display("FAIL bp_idle got=%h want=%h", obs, ZERO_VEC); end
  endtask

  task automatic test_zero_count();
    start = 1'b1; start_row = IW'($urandom_range(0, 2047)); count = '0; addr_ready = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (obs !== DONE_VEC) begin bad++; $display("FAIL zero_done got=%h want=%h", obs, DONE_VEC); end
    repeat (2) begin
      tick();
      total++;
      if (obs !== ZERO_VEC) begin bad++; $display("FAIL zero_idle got=%h want=%h", obs, ZERO_VEC); end
    end
  endtask

  task automatic test_start_while_busy();
    int unsigned cyc;
    model_run(37, 3);
    start = 1'b1; start_row = IW'(37); count = IW'(3); addr_ready = 1'b0;
    tick();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      total++;
      if (obs !== beat_vec(exp_q[0])) begin
        bad++; $display("FAIL busy_beat cyc=%0d got=%h want=%h", cyc, obs, beat_vec(exp_q[0]));
      end
      start      = (cyc < 3) ? 1'b1 : 1'b0;
      start_row  = IW'(500);
      count      = IW'(5);
      addr_ready = (cyc < 3) ? 1'b0 : 1'b1;
      tick();
      if (addr_ready) void'(exp_q.pop_front());
      cyc++;
    end
    start = 1'b0;
    total++;
    if (obs !== DONE_VEC) begin bad++; $display("FAIL busy_done got=%h want=%h", obs, DONE_VEC); end
    repeat (2) begin
      tick();
      total++;
      if (obs !== ZERO_VEC) begin bad++; $display("FAIL busy_no_queue got=%h want=%h", obs, ZERO_VEC); end
    end
  endtask

  task automatic test_reset_mid_run();
    model_run(10, 10);
    start = 1'b1; start_row = IW'(10); count = IW'(10); addr_ready = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (obs !== beat_vec(exp_q[0])) begin bad++; $display("FAIL rst_beat1 got=%h want=%h", obs, beat_vec(exp_q[0])); end
    tick();
    void'(exp_q.pop_front());
    total++;
    if (obs !== beat_vec(exp_q[0])) begin bad++; $display("FAIL rst_beat2 got=%h want=%h", obs, beat_vec(exp_q[0])); end
    reset = 1'b1;
    tick();
    total++;
    if (obs !== ZERO_VEC) begin bad++; $display("FAIL rst_abort got=%h want=%h", obs, ZERO_VEC); end
    reset = 1'b0; addr_ready = 1'b0;
    repeat (2) begin
      tick();
      total++;
      if (obs !== ZERO_VEC) begin bad++; $display("FAIL rst_no_done got=%h want=%h", obs, ZERO_VEC); end
    end
  endtask

  task automatic test_random();
    int unsigned sr, cnt, cyc;
    for (int r = 0; r < 40; r++) begin
      sr = $urandom_range(0, 2047);
      if (r % 8 == 7) cnt = 0;
      else if ($urandom_range(0, 3) == 0) cnt = $urandom_range(1, 300);
      else cnt = $urandom_range(1, 40);
      model_run(sr, cnt);
      // Starts issued on the done cycle of the previous run exercise back-to-back acceptance.
      start = 1'b1; start_row = IW'(sr); count = IW'(cnt);
      tick();
      start = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 8 * cnt + 20) begin
        total++;
        if (obs !== beat_vec(exp_q[0])) begin
          bad++; $display("FAIL rand_beat run=%0d cyc=%0d got=%h want=%h", r, cyc, obs, beat_vec(exp_q[0]));
        end
        addr_ready = 1'($urandom_range(0, 1));
        tick();
        if (addr_ready) void'(exp_q.pop_front());
        cyc++;
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++; $display("FAIL rand_timeout run=%0d left=%0d want=0", r, exp_q.size());
        return;
      end
      total++;
      if (obs !== DONE_VEC) begin bad++; $display("FAIL rand_done run=%0d got=%h want=%h", r, obs, DONE_VEC); end
    end
    tick();
    total++;
    if (obs !== ZERO_VEC) begin bad++; $display("FAIL rand_idle got=%h want=%h", obs, ZERO_VEC); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
